// File: rtl/hack_program_loader.sv
// rtl/hack_program_loader.sv - UART bootloader that streams Hack instruction words into instruction RAM.
// Optional trailing checksum byte enabled by defining HACK_LOADER_CHECKSUM_EN.
module hack_program_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_WIDTH   = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic                  rom_we,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic [15:0]           rom_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0]    SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  typedef enum logic [2:0] {
    S_SYNC, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO,
`ifdef HACK_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE, S_ERR
  } state_t;

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t       rx_state_q, rx_state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_valid, frame_err;
  logic [7:0]      rx_byte;

  state_t                state_q, state_d;
  logic [7:0]            len_hi_q, len_hi_d;
  logic [15:0]           len_q, len_d;
  logic [7:0]            hi_q, hi_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rom_we_q, rom_we_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [15:0]           rom_data_q, rom_data_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  load_start;
  logic [15:0]           len_now;
  logic                  last_word;

  // Byte strobes fire in the stop-bit sample cycle so a write lands one clock later.
  always_comb begin
    rx_state_d = rx_state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          cnt_d      = '0;
        end
      end
      RX_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d      = '0;
          bit_idx_d  = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_BIT) begin
          cnt_d     = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_BIT) begin
          byte_valid = rx_sync_q;
          frame_err  = !rx_sync_q;
          rx_state_d = RX_IDLE;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign rx_byte    = shift_q;
  assign load_start = byte_valid && (rx_byte == SYNC_BYTE) &&
                      (state_q == S_SYNC || state_q == S_DONE || state_q == S_ERR);
  assign len_now    = {len_hi_q, rx_byte};
  assign last_word  = (32'(addr_q) + 32'd1) == 32'(len_q);

`ifdef HACK_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (load_start)
      csum_d = '0;
    else if (byte_valid && (state_q inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO}))
      csum_d = csum_q + rx_byte;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) csum_q <= '0;
    else        csum_q <= csum_d;
  end
`endif

  always_comb begin
    state_d    = state_q;
    len_hi_d   = len_hi_q;
    len_d      = len_q;
    hi_d       = hi_q;
    addr_d     = addr_q;
    rom_we_d   = 1'b0;
    rom_addr_d = rom_addr_q;
    rom_data_d = rom_data_q;
    cpu_hold_d = cpu_hold_q;
    done_d     = done_q;
    error_d    = error_q;

    if (load_start) begin
      state_d    = S_LEN_HI;
      cpu_hold_d = 1'b1;
      done_d     = 1'b0;
      error_d    = 1'b0;
      addr_d     = '0;
    end else if (byte_valid) begin
      case (state_q)
        S_LEN_HI: begin
          len_hi_d = rx_byte;
          state_d  = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_d = len_now;
          if (32'(len_now) > (32'd1 << ADDR_WIDTH)) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else if (len_now == 16'd0) begin
`ifdef HACK_LOADER_CHECKSUM_EN
            state_d    = S_CSUM;
`else
            state_d    = S_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
`endif
          end else begin
            state_d = S_DATA_HI;
          end
        end
        S_DATA_HI: begin
          hi_d    = rx_byte;
          state_d = S_DATA_LO;
        end
        S_DATA_LO: begin
          rom_we_d   = 1'b1;
          rom_addr_d = addr_q;
          rom_data_d = {hi_q, rx_byte};
          // Address holds on the last word so a full-capacity load never wraps.
          if (last_word) begin
`ifdef HACK_LOADER_CHECKSUM_EN
            state_d    = S_CSUM;
`else
            state_d    = S_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
`endif
          end else begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = S_DATA_HI;
          end
        end
`ifdef HACK_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (rx_byte == csum_q) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end else if (frame_err && !(state_q inside {S_SYNC, S_DONE, S_ERR})) begin
      state_d = S_ERR;
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      state_q    <= S_SYNC;
      len_hi_q   <= '0;
      len_q      <= '0;
      hi_q       <= '0;
      addr_q     <= '0;
      rom_we_q   <= 1'b0;
      rom_addr_q <= '0;
      rom_data_q <= '0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      len_q      <= len_d;
      hi_q       <= hi_d;
      addr_q     <= addr_d;
      rom_we_q   <= rom_we_d;
      rom_addr_q <= rom_addr_d;
      rom_data_q <= rom_data_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign rom_we   = rom_we_q;
  assign rom_addr = rom_addr_q;
  assign rom_data = rom_data_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_hack_program_loader.sv
// tb/tb_hack_program_loader.sv - scoreboard bench for hack_program_loader.
module tb_hack_program_loader;

  localparam int CPB = 4;
  localparam int AW  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx;
  logic          rom_we;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data;
  logic          cpu_hold;
  logic          done;
  logic          error;

  int checks = 0;
  int errors = 0;

  logic [AW+15:0] exp_q[$];
  logic [15:0]    frame_w[$];
`ifdef HACK_LOADER_CHECKSUM_EN
  logic [7:0]     csum_delta = 8'd0;
`endif

  hack_program_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .rom_we   (rom_we),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    logic [AW+15:0] exp;
    @(negedge clk);
    if (rom_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0h data=%04h, required no write", rom_addr, rom_data);
      end else begin
        exp = exp_q.pop_front();
        if ({rom_addr, rom_data} !== exp) begin
          errors++;
          $display("FAIL write: got addr=%0h data=%04h, required addr=%0h data=%04h",
                   rom_addr, rom_data, exp[AW+15:16], exp[15:0]);
        end
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    ticks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      ticks(CPB);
    end
    rx = stop_bit;
    ticks(CPB);
    rx = 1'b1;
    ticks(2 * CPB);
  endtask

  task automatic do_reset();
    rx    = 1'b1;
    reset = 1'b0;
    ticks(3);
    reset = 1'b1;
    ticks(2);
    exp_q.delete();
  endtask

  task automatic send_frame(input int len);
    logic [15:0] w;
`ifdef HACK_LOADER_CHECKSUM_EN
    logic [7:0] sum;
    sum = 8'(len >> 8) + 8'(len);
`endif
    send_byte(8'hA5, 1'b1);
    checks++;
    if (cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL hold_after_sync: got cpu_hold=%b, required 1", cpu_hold);
    end
    send_byte(8'(len >> 8), 1'b1);
    send_byte(8'(len), 1'b1);
    for (int i = 0; i < frame_w.size(); i++) begin
      w = frame_w[i];
      exp_q.push_back({AW'(i), w});
      send_byte(w[15:8], 1'b1);
      send_byte(w[7:0], 1'b1);
`ifdef HACK_LOADER_CHECKSUM_EN
      sum = sum + w[15:8] + w[7:0];
`endif
      if (i == 0 && frame_w.size() > 1) begin
        checks++;
        if (cpu_hold !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL hold_mid_frame: got cpu_hold=%b done=%b, required 1 0", cpu_hold, done);
        end
      end
    end
`ifdef HACK_LOADER_CHECKSUM_EN
    checks++;
    if (cpu_hold !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL hold_before_trailer: got cpu_hold=%b done=%b, required 1 0", cpu_hold, done);
    end
    send_byte(sum + csum_delta, 1'b1);
`endif
    ticks(4);
  endtask

  task automatic test_reset();
    int bad;
    bad   = 0;
    rx    = 1'b1;
    reset = 1'b0;
    ticks(2);
    checks++;
    if ({rom_we, rom_addr, rom_data, cpu_hold, done, error} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b addr=%0h data=%04h hold=%b done=%b err=%b, required all 0",
               rom_we, rom_addr, rom_data, cpu_hold, done, error);
    end
    reset = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (rom_we !== 1'b0 || cpu_hold !== 1'b0 || done !== 1'b0 || error !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_quiet: got %0d active cycles, required 0", bad);
    end
  endtask

  task automatic test_load();
    do_reset();
    frame_w = '{16'h1234, 16'hABCD};
    send_frame(2);
    checks++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL load_done: got done=%b hold=%b err=%b, required 1 0 0", done, cpu_hold, error);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL load_writes: got %0d missing writes, required 0", exp_q.size());
    end
  endtask

`ifdef HACK_LOADER_CHECKSUM_EN
  task automatic test_bad_csum();
    do_reset();
    frame_w    = '{16'h1234, 16'hABCD};
    csum_delta = 8'd1;
    send_frame(2);
    csum_delta = 8'd0;
    checks++;
    if (error !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL bad_csum: got err=%b done=%b hold=%b, required 1 0 1", error, done, cpu_hold);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bad_csum_writes: got %0d missing writes, required 0", exp_q.size());
    end
    frame_w.delete();
    send_frame(0);
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL empty_reload: got done=%b err=%b hold=%b, required 1 0 0", done, error, cpu_hold);
    end
  endtask
`endif

  task automatic test_len_overflow();
    do_reset();
    frame_w.delete();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'((1 << AW) + 1), 1'b1);
    ticks(4);
    checks++;
    if (error !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL len_overflow: got err=%b hold=%b done=%b, required 1 1 0", error, cpu_hold, done);
    end
    send_frame(0);
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL overflow_reload: got done=%b err=%b hold=%b, required 1 0 0", done, error, cpu_hold);
    end
  endtask

  task automatic test_framing();
    do_reset();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h12, 1'b0);
    ticks(4);
    checks++;
    if (error !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL framing: got err=%b hold=%b done=%b, required 1 1 0", error, cpu_hold, done);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    rx = 1'b0;
    tick();
    rx = 1'b1;
    ticks(20);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    checks++;
    if (cpu_hold !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL sync_ignore: got hold=%b done=%b err=%b, required 0 0 0", cpu_hold, done, error);
    end
    send_byte(8'hA5, 1'b1);
    checks++;
    if (cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL sync_after_glitch: got cpu_hold=%b, required 1", cpu_hold);
    end
  endtask

  task automatic test_reset_midload();
    do_reset();
    exp_q.push_back({AW'(0), 16'h1234});
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({rom_we, rom_addr, rom_data, cpu_hold, done, error} !== '0) begin
      errors++;
      $display("FAIL async_reset: got we=%b addr=%0h data=%04h hold=%b done=%b err=%b, required all 0",
               rom_we, rom_addr, rom_data, cpu_hold, done, error);
    end
    ticks(2);
    reset = 1'b1;
    ticks(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL prereset_write: got %0d missing writes, required 0", exp_q.size());
    end
    frame_w = '{16'h0F0F, 16'h8001, 16'h7E7E};
    send_frame(3);
    checks++;
    if (done !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL reload_after_reset: got done=%b pending=%0d, required 1 0", done, exp_q.size());
    end
  endtask

  task automatic test_max_len();
    do_reset();
    frame_w.delete();
    for (int i = 0; i < (1 << AW); i++) frame_w.push_back(16'($urandom));
    send_frame(1 << AW);
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL max_len: got done=%b err=%b hold=%b pending=%0d, required 1 0 0 0",
               done, error, cpu_hold, exp_q.size());
    end
  endtask

  initial begin
    reset = 1'b0;
    rx    = 1'b1;
    test_reset();
    test_load();
`ifdef HACK_LOADER_CHECKSUM_EN
    test_bad_csum();
`endif
    test_len_overflow();
    test_framing();
    test_glitch();
    test_reset_midload();
    test_max_len();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
